mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port synchronous RAM: fixed m0 priority with
// m1 starvation relief, and bounded exclusive lock ownership for read-modify-write.
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wea,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wea,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic [3:0]        ram_wea,
    input  logic [31:0]       ram_dout,
    output logic              starved
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_starve_cnt;
    logic [LW-1:0]     r_lock_cnt;
    logic              r_blk0;
    logic              r_blk1;
    logic              r_rvld0_p1;
    logic              r_rvld1_p1;
    logic [31:0]       r_rdata0_p1;
    logic [31:0]       r_rdata1_p1;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_din;

    logic w_g0;
    logic w_g1;
    logic w_arb;
    logic w_starved;
    logic w_force0;
    logic w_force1;

    assign w_starved = (r_starve_cnt == STARVE_LIM);
    assign w_force0  = (r_state == LOCK0) && m0_lock && (r_lock_cnt == LOCK_LAST);
    assign w_force1  = (r_state == LOCK1) && m1_lock && (r_lock_cnt == LOCK_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_g0        = 1'b0;
        w_g1        = 1'b0;
        w_arb       = 1'b0;
        case (r_state)
            LOCK0: begin
                if (m0_lock) begin
                    w_g0 = m0_req;
                    if (r_lock_cnt == LOCK_LAST) w_state_nxt = IDLE;
                end else begin
                    w_arb = 1'b1;
                end
            end
            LOCK1: begin
                if (m1_lock) begin
                    w_g1 = m1_req;
                    if (r_lock_cnt == LOCK_LAST) w_state_nxt = IDLE;
                end else begin
                    w_arb = 1'b1;
                end
            end
            default: w_arb = 1'b1;
        endcase
        // Lock requests right after a forced release are ignored until the lock line drops.
        if (w_arb) begin
            w_state_nxt = IDLE;
            if (m0_req && (!m1_req || !w_starved)) begin
                w_g0 = 1'b1;
                if (m0_lock && !r_blk0) w_state_nxt = LOCK0;
            end else if (m1_req) begin
                w_g1 = 1'b1;
                if (m1_lock && !r_blk1) w_state_nxt = LOCK1;
            end
        end
        if (rst) begin
            w_g0 = 1'b0;
            w_g1 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_lock_cnt   <= '0;
            r_blk0       <= 1'b0;
            r_blk1       <= 1'b0;
            r_rvld0_p1   <= 1'b0;
            r_rvld1_p1   <= 1'b0;
            r_rdata0_p1  <= '0;
            r_rdata1_p1  <= '0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == IDLE || w_state_nxt != r_state)
                r_lock_cnt <= '0;
            else
                r_lock_cnt <= r_lock_cnt + 1'b1;
            if (m1_req && !w_g1)
                r_starve_cnt <= w_starved ? r_starve_cnt : r_starve_cnt + 1'b1;
            else
                r_starve_cnt <= '0;
            if (w_force0)     r_blk0 <= 1'b1;
            else if (!m0_lock) r_blk0 <= 1'b0;
            if (w_force1)     r_blk1 <= 1'b1;
            else if (!m1_lock) r_blk1 <= 1'b0;
            // Stage p1: RAM returns read data one cycle after the granted address.
            r_rvld0_p1 <= w_g0 && (m0_wea == 4'b0000);
            r_rvld1_p1 <= w_g1 && (m1_wea == 4'b0000);
            if (r_rvld0_p1) r_rdata0_p1 <= ram_dout;
            if (r_rvld1_p1) r_rdata1_p1 <= ram_dout;
            if (w_g0) begin
                r_ram_addr <= m0_addr;
                r_ram_din  <= m0_wdata;
            end else if (w_g1) begin
                r_ram_addr <= m1_addr;
                r_ram_din  <= m1_wdata;
            end
        end
    end

    assign m0_gnt    = w_g0;
    assign m1_gnt    = w_g1;
    assign m0_rvalid = r_rvld0_p1 && !rst;
    assign m1_rvalid = r_rvld1_p1 && !rst;
    assign m0_rdata  = rst ? 32'h0 : (r_rvld0_p1 ? ram_dout : r_rdata0_p1);
    assign m1_rdata  = rst ? 32'h0 : (r_rvld1_p1 ? ram_dout : r_rdata1_p1);
    assign starved   = w_starved && !rst;

    always_comb begin
        ram_addr = rst ? '0 : r_ram_addr;
        ram_din  = rst ? '0 : r_ram_din;
        ram_wea  = 4'b0000;
        if (w_g0) begin
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
            ram_wea  = m0_wea;
        end else if (w_g1) begin
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
            ram_wea  = m1_wea;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read/write paths, starvation rotation,
// lock hold, lock timeout and reset during an outstanding read.
module tb_mem_arbiter;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_lock, m1_req, m1_lock;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [31:0]       m0_wdata, m1_wdata;
    logic [3:0]        m0_wea, m1_wea;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]       m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din, ram_dout;
    logic [3:0]        ram_wea;
    logic              starved;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(8), .LOCK_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wea(m0_wea), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wea(m1_wea), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wea(ram_wea), .ram_dout(ram_dout),
        .starved(starved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " m0_gnt"}, 32'(m0_gnt), 0);
        chk({tag, " m1_gnt"}, 32'(m1_gnt), 0);
        chk({tag, " m0_rvalid"}, 32'(m0_rvalid), 0);
        chk({tag, " m1_rvalid"}, 32'(m1_rvalid), 0);
        chk({tag, " m0_rdata"}, m0_rdata, 0);
        chk({tag, " m1_rdata"}, m1_rdata, 0);
        chk({tag, " ram_addr"}, 32'(ram_addr), 0);
        chk({tag, " ram_din"}, ram_din, 0);
        chk({tag, " ram_wea"}, 32'(ram_wea), 0);
        chk({tag, " starved"}, 32'(starved), 0);
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0; m0_wea = '0;
        m1_req = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0; m1_wea = '0;
        ram_dout = '0;
        next_cycle();
        @(negedge clk);
        check_reset_outputs("reset");
        next_cycle();
        rst = 1'b0;

        // single read by m0
        m0_req = 1; m0_addr = 10'h005; m0_wea = 4'b0000;
        @(negedge clk);
        chk("rd m0_gnt", 32'(m0_gnt), 1);
        chk("rd m1_gnt", 32'(m1_gnt), 0);
        chk("rd ram_addr", 32'(ram_addr), 32'h005);
        chk("rd ram_wea", 32'(ram_wea), 0);
        next_cycle();
        m0_req = 0; ram_dout = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd m0_rvalid", 32'(m0_rvalid), 1);
        chk("rd m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd m1_rvalid", 32'(m1_rvalid), 0);
        next_cycle();
        ram_dout = 32'h0;
        @(negedge clk);
        chk("rd rvalid low", 32'(m0_rvalid), 0);
        chk("rd rdata hold", m0_rdata, 32'hDEADBEEF);
        chk("rd addr hold", 32'(ram_addr), 32'h005);
        next_cycle();

        // m1 partial write
        m1_req = 1; m1_addr = 10'h03A; m1_wdata = 32'h12345678; m1_wea = 4'b0011;
        @(negedge clk);
        chk("wr m1_gnt", 32'(m1_gnt), 1);
        chk("wr ram_wea", 32'(ram_wea), 32'h3);
        chk("wr ram_din", ram_din, 32'h12345678);
        chk("wr ram_addr", 32'(ram_addr), 32'h03A);
        next_cycle();
        m1_req = 0; m1_wea = 4'b0000;
        @(negedge clk);
        chk("wr m1_rvalid", 32'(m1_rvalid), 0);
        chk("wr idle wea", 32'(ram_wea), 0);
        chk("wr din hold", ram_din, 32'h12345678);
        next_cycle();

        // continuous contention: 8 m0 grants, then one starved m1 grant, repeated
        m0_req = 1; m1_req = 1; m0_addr = 10'h010; m1_addr = 10'h020;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            chk($sformatf("cont%0d m0_gnt", c), 32'(m0_gnt), (c % 9 != 0) ? 1 : 0);
            chk($sformatf("cont%0d m1_gnt", c), 32'(m1_gnt), (c % 9 == 0) ? 1 : 0);
            chk($sformatf("cont%0d starved", c), 32'(starved), (c % 9 == 0) ? 1 : 0);
            next_cycle();
        end
        m0_req = 0; m1_req = 0;
        next_cycle();

        // m1 lock holds off m0
        m1_req = 1; m1_lock = 1;
        @(negedge clk);
        chk("lk1 take m1_gnt", 32'(m1_gnt), 1);
        next_cycle();
        m0_req = 1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("lk1 hold%0d m0_gnt", c), 32'(m0_gnt), 0);
            chk($sformatf("lk1 hold%0d m1_gnt", c), 32'(m1_gnt), 1);
            next_cycle();
        end
        m1_lock = 0;
        @(negedge clk);
        chk("lk1 drop m0_gnt", 32'(m0_gnt), 1);
        chk("lk1 drop m1_gnt", 32'(m1_gnt), 0);
        next_cycle();
        m0_req = 0; m1_req = 0;
        next_cycle();

        // m0 lock held 20 cycles: 16 cycles in LOCK0, then forced release
        m0_req = 1; m0_lock = 1;
        for (int c = 0; c <= 19; c++) begin
            if (c == 1) m1_req = 1;
            if (c == 19) m0_req = 0;
            @(negedge clk);
            if (c <= 16) begin
                chk($sformatf("lk0 c%0d m0_gnt", c), 32'(m0_gnt), 1);
                chk($sformatf("lk0 c%0d m1_gnt", c), 32'(m1_gnt), 0);
                chk($sformatf("lk0 c%0d starved", c), 32'(starved), (c >= 9) ? 1 : 0);
            end else if (c == 17) begin
                chk("lk0 release m1_gnt", 32'(m1_gnt), 1);
                chk("lk0 release m0_gnt", 32'(m0_gnt), 0);
                chk("lk0 release starved", 32'(starved), 1);
            end else if (c == 18) begin
                chk("lk0 after m0_gnt", 32'(m0_gnt), 1);
                chk("lk0 after m1_gnt", 32'(m1_gnt), 0);
            end else begin
                chk("lk0 ignored m1_gnt", 32'(m1_gnt), 1);
                chk("lk0 ignored m0_gnt", 32'(m0_gnt), 0);
            end
            next_cycle();
        end
        m0_lock = 0; m1_req = 0;
        next_cycle();

        // reset while a read is in flight
        m0_req = 1; m0_addr = 10'h007; m0_wea = 4'b0000;
        @(negedge clk);
        chk("rstrd m0_gnt", 32'(m0_gnt), 1);
        next_cycle();
        rst = 1; ram_dout = 32'hCAFEF00D; m1_req = 1;
        @(negedge clk);
        check_reset_outputs("rstrd");
        next_cycle();
        rst = 0; m0_req = 0; ram_dout = 32'h0;
        @(negedge clk);
        chk("rstrd after rvalid", 32'(m0_rvalid), 0);
        chk("rstrd first m1_gnt", 32'(m1_gnt), 1);
        chk("rstrd first m0_gnt", 32'(m0_gnt), 0);
        next_cycle();
        m1_req = 0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
